// File: rtl/ext_pkg.sv
// Operation codes shared between the operand extender and the instruction decoder.
package ext_pkg;

    localparam int unsigned EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZEXT = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_SEXT = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_LUI  = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_LB   = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_LBU  = 3'd4;
    localparam logic [EXT_OP_W-1:0] EXT_LH   = 3'd5;
    localparam logic [EXT_OP_W-1:0] EXT_LHU  = 3'd6;
    localparam logic [EXT_OP_W-1:0] EXT_RSVD = 3'd7;

endpackage

// File: rtl/ext_core.sv
// Combinational extender: immediate zero/sign extension, lui placement and
// little-endian byte/halfword extraction from the low 32 bits of a load word.
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic [EXT_OP_W-1:0] op_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [1:0]          off_i,
    output logic [DATA_W-1:0]   result_o,
    output logic                err_o
);

    logic [IMM_W-1:0] imm;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    assign imm    = data_i[IMM_W-1:0];
    assign half_v = off_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        byte_v = data_i[7:0];
        unique case (off_i)
            2'd0: byte_v = data_i[7:0];
            2'd1: byte_v = data_i[15:8];
            2'd2: byte_v = data_i[23:16];
            2'd3: byte_v = data_i[31:24];
        endcase
    end

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_i)
            EXT_ZEXT: result_o = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_SEXT: result_o = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            EXT_LUI:  result_o = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_LB:   result_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
            EXT_LBU:  result_o = {{(DATA_W-8){1'b0}}, byte_v};
            EXT_LH: begin
                result_o = {{(DATA_W-16){half_v[15]}}, half_v};
                err_o    = off_i[0];
            end
            EXT_LHU: begin
                result_o = {{(DATA_W-16){1'b0}}, half_v};
                err_o    = off_i[0];
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Buffered operand extender: ext_core result pushed into a DEPTH-entry FIFO
// with valid/ready on both sides and a synchronous flush.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXT_OP_W-1:0]          in_op,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [1:0]                   in_off,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_W:0]    mem_q [DEPTH];
    logic [DATA_W:0]    head_q, head_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  core_res;
    logic               core_err;
    logic               push, pop;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .op_i     (in_op),
        .data_i   (in_data),
        .off_i    (in_off),
        .result_o (core_res),
        .err_o    (core_err)
    );

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;
    assign out_data  = head_q[DATA_W-1:0];
    assign out_err   = head_q[DATA_W];

    // head_q mirrors the entry at rd_ptr so outputs are register-driven; when
    // the FIFO drains it keeps the last popped entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (count_d != '0) begin
                head_d = (push && (rd_ptr_d == wr_ptr_q)) ? {core_err, core_res}
                                                          : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (push) mem_q[wr_ptr_q] <= {core_err, core_res};
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized and directed bench for ext_pipe against a queue-based reference model.
module tb_ext_pipe;
    import ext_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [31:0]   in_data = '0;
    logic [1:0]    in_off = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic          out_err;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_err    = 0;

    logic [32:0] q[$];
    logic [32:0] last = '0;

    ext_pipe #(
        .DATA_W (32),
        .IMM_W  (16),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_off    (in_off),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {err, result} from the op rules, in plain arithmetic.
    function automatic logic [32:0] ref_ext(input logic [2:0] op, input logic [31:0] d,
                                            input logic [1:0] off);
        int unsigned offs, b, h, imm;
        logic [31:0] r;
        logic        e;
        offs = off;
        b    = (d >> (8 * offs)) & 32'hFF;
        h    = (d >> (16 * (offs / 2))) & 32'hFFFF;
        imm  = d & 32'hFFFF;
        e    = 1'b0;
        case (op)
            3'd0: r = imm;
            3'd1: r = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
            3'd2: r = imm * 65536;
            3'd3: r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: r = b;
            3'd5: begin r = (h >= 32768) ? h + 32'hFFFF_0000 : h; e = (offs % 2) == 1; end
            3'd6: begin r = h; e = (offs % 2) == 1; end
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    task automatic check_state();
        logic [32:0] exp_head;
        int unsigned sz;
        sz       = q.size();
        exp_head = (sz != 0) ? q[0] : last;
        check("count", 64'(count), 64'(sz));
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        check("out_data", 64'(out_data), 64'(exp_head[31:0]));
        check("out_err", 64'(out_err), 64'(exp_head[32]));
    endtask

    // One clock: check registered state, drive inputs, advance the model at the edge.
    task automatic cyc(input bit v, input logic [2:0] op, input logic [31:0] d,
                       input logic [1:0] off, input bit ordy, input bit fl);
        bit push, pop;
        check_state();
        in_valid  = v;
        in_op     = op;
        in_data   = d;
        in_off    = off;
        out_ready = ordy;
        flush     = fl;
        push = v && (q.size() < DEPTH) && !fl;
        pop  = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            last = '0;
        end else begin
            if (pop)  last = q.pop_front();
            if (push) q.push_back(ref_ext(op, d, off));
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held low: check reset state, then release between edges.
        @(negedge clk);
        check_state();
        @(negedge clk);
        reset = 1'b1;

        // Immediate forms, one per cycle with out_ready high.
        cyc(1, EXT_ZEXT, 32'h0000_8001, 2'd0, 1, 0);
        cyc(1, EXT_SEXT, 32'h0000_8001, 2'd0, 1, 0);
        cyc(1, EXT_LUI,  32'h0000_8001, 2'd0, 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, EXT_LB,  32'h80FF_7F01, 2'(k), 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, EXT_LBU, 32'h80FF_7F01, 2'(k), 1, 0);
        cyc(1, EXT_LH,   32'h8000_1234, 2'd2, 1, 0);
        cyc(1, EXT_LH,   32'h8000_1234, 2'd1, 1, 0);
        cyc(1, EXT_LHU,  32'h8000_1234, 2'd3, 1, 0);
        cyc(1, EXT_RSVD, 32'hDEAD_BEEF, 2'd0, 1, 0);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);

        // Fill with consumer stalled, third push refused, then drain in order.
        cyc(1, EXT_SEXT, 32'h0000_F00D, 2'd0, 0, 0);
        cyc(1, EXT_LUI,  32'h0000_ABCD, 2'd0, 0, 0);
        cyc(1, EXT_ZEXT, 32'h0000_1111, 2'd0, 0, 0);
        cyc(1, EXT_LBU,  32'h1234_5678, 2'd3, 1, 0);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);

        // Flush while full with input and pop both offered.
        cyc(1, EXT_LB, 32'h0000_0080, 2'd0, 0, 0);
        cyc(1, EXT_LH, 32'hFFFF_0001, 2'd2, 0, 0);
        cyc(1, EXT_ZEXT, 32'h0000_7777, 2'd0, 1, 1);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);

        // Asynchronous reset between edges with two entries queued.
        cyc(1, EXT_SEXT, 32'h0000_9999, 2'd0, 0, 0);
        cyc(1, EXT_LHU,  32'h5555_AAAA, 2'd0, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        last = '0;
        check_state();
        @(negedge clk);
        reset = 1'b1;
        cyc(1, EXT_LBU, 32'h00C3_0000, 2'd2, 1, 0);
        cyc(0, EXT_ZEXT, 32'h0, 2'd0, 1, 0);

        // Randomized traffic with stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0);
        end
        check_state();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
